// File: rtl/blastn_pkg.sv
// Shared definitions for the seed dispatch block and the UGPE.
// Request field layout, sequence geometry and FSM states.
package blastn_pkg;

    localparam int SEQ_LEN   = 16;
    localparam int BASE_BITS = 2;
    localparam int WORD_W    = SEQ_LEN * BASE_BITS;
    localparam int JOB_W     = 96;
    localparam int REQ_W     = 128;

    localparam int QRY_LSB = 0;
    localparam int DB_LSB  = 32;
    localparam int QS_LSB  = 64;
    localparam int DS_LSB  = 80;
    localparam int HIT_LSB = 96;
    localparam int LEN_LSB = 112;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } state_t;

    // Job word already matches the low 96 request bits.
    function automatic logic [REQ_W-1:0] pack_req(
        input logic [JOB_W-1:0] job,
        input logic [4:0]       hit
    );
        logic [REQ_W-1:0] r;
        r = '0;
        r[JOB_W-1:0]        = job;
        r[HIT_LSB +: 16]    = {11'd0, hit};
        r[LEN_LSB +: 16]    = 16'(SEQ_LEN);
        return r;
    endfunction

endpackage

// File: rtl/project_kmer_eqvec.sv
// Per-base equality vector between query and database words.
// Purely combinational.
module project_kmer_eqvec
    import blastn_pkg::*;
(
    input  logic [WORD_W-1:0]  i_query,
    input  logic [WORD_W-1:0]  i_database,
    output logic [SEQ_LEN-1:0] o_eqvec
);

    // Compare each 2-bit base pair on the diagonal
    always_comb begin
        o_eqvec = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            o_eqvec[i] = (i_query[i*BASE_BITS +: BASE_BITS] ==
                          i_database[i*BASE_BITS +: BASE_BITS]);
        end
    end

endmodule

// File: rtl/project_seed_dispatch.sv
// Scans one query/database word pair for exact K-mer seeds and
// emits one non-overlapping extension request per seed.
module project_seed_dispatch
    import blastn_pkg::*;
#(
    parameter int K        = 4,
    parameter int MAX_HITS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         istream_val,
    output logic         istream_rdy,
    input  logic [95:0]  istream_msg,
    output logic         ostream_val,
    input  logic         ostream_rdy,
    output logic [127:0] ostream_msg
);

    state_t r_state;
    state_t w_state_n;

    logic [4:0]       r_pos;
    logic [4:0]       r_hit_cnt;
    logic [4:0]       r_hit;
    logic [JOB_W-1:0] r_job;

    logic [4:0]       w_pos_n;
    logic [4:0]       w_cnt_n;
    logic [4:0]       w_hit_n;
    logic             w_load;

    logic [SEQ_LEN-1:0] w_eq;
    logic [SEQ_LEN-1:0] w_win;
    logic               w_seed;
    logic [5:0]         w_next6;
    logic [4:0]         w_cnt_inc;
    logic               w_last;

    project_kmer_eqvec u_eqvec (
        .i_query    (r_job[QRY_LSB +: WORD_W]),
        .i_database (r_job[DB_LSB  +: WORD_W]),
        .o_eqvec    (w_eq)
    );

    // K-wide AND window ending just below each legal position
    for (genvar p = 0; p < SEQ_LEN; p++) begin : g_win
        if (p >= K) begin : g_on
            assign w_win[p] = &w_eq[p-1 -: K];
        end else begin : g_off
            assign w_win[p] = 1'b0;
        end
    end

    assign w_seed    = w_win[r_pos[3:0]] & ~r_pos[4];
    assign w_next6   = {1'b0, r_hit} + 6'(K);
    assign w_cnt_inc = r_hit_cnt + 5'd1;
    assign w_last    = (w_cnt_inc == 5'(MAX_HITS)) ||
                       (w_next6 > 6'(SEQ_LEN - 1));

    // Next-state, datapath updates and Moore outputs
    always_comb begin
        w_state_n   = r_state;
        w_pos_n     = r_pos;
        w_cnt_n     = r_hit_cnt;
        w_hit_n     = r_hit;
        w_load      = 1'b0;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        unique case (r_state)
            IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    w_load    = 1'b1;
                    w_pos_n   = 5'(K);
                    w_cnt_n   = 5'd0;
                    w_state_n = SCAN;
                end
            end
            SCAN: begin
                if (w_seed) begin
                    w_hit_n   = r_pos;
                    w_state_n = EMIT;
                end else if (r_pos == 5'(SEQ_LEN - 1)) begin
                    w_state_n = IDLE;
                end else begin
                    w_pos_n = r_pos + 5'd1;
                end
            end
            EMIT: begin
                ostream_val = 1'b1;
                if (ostream_rdy) begin
                    w_cnt_n = w_cnt_inc;
                    if (w_last) begin
                        w_state_n = IDLE;
                    end else begin
                        w_pos_n   = w_next6[4:0];
                        w_state_n = SCAN;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign ostream_msg = pack_req(r_job, r_hit) & {REQ_W{ostream_val}};

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_n;
    end

    // Scan position, hit bookkeeping and captured job
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos     <= 5'd0;
            r_hit_cnt <= 5'd0;
            r_hit     <= 5'd0;
            r_job     <= '0;
        end else begin
            r_pos     <= w_pos_n;
            r_hit_cnt <= w_cnt_n;
            r_hit     <= w_hit_n;
            if (w_load) r_job <= istream_msg;
        end
    end

endmodule

// File: tb/tb_project_seed_dispatch.sv
// Bench for project_seed_dispatch: directed scenarios plus
// randomized jobs against a seed-list reference model.
module tb_project_seed_dispatch;

    localparam int K = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         val;
    logic [95:0]  imsg;
    logic         ordy;
    bit           sel;

    logic         val1, val2;
    logic         irdy1, irdy2, oval1, oval2;
    logic [127:0] omsg1, omsg2;
    logic         irdy, oval;
    logic [127:0] omsg;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign val1 = val && !sel;
    assign val2 = val && sel;
    assign irdy = sel ? irdy2 : irdy1;
    assign oval = sel ? oval2 : oval1;
    assign omsg = sel ? omsg2 : omsg1;

    project_seed_dispatch #(.K(K), .MAX_HITS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (val1),
        .istream_rdy (irdy1),
        .istream_msg (imsg),
        .ostream_val (oval1),
        .ostream_rdy (ordy),
        .ostream_msg (omsg1)
    );

    project_seed_dispatch #(.K(K), .MAX_HITS(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .istream_val (val2),
        .istream_rdy (irdy2),
        .istream_msg (imsg),
        .ostream_val (oval2),
        .ostream_rdy (ordy),
        .ostream_msg (omsg2)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected seed list: leftmost exact K-run, then skip past it
    task automatic build_model(input logic [31:0] q, input logic [31:0] d,
                               input int mh);
        bit eq[16];
        int p;
        bit ok;
        exp_q.delete();
        for (int i = 0; i < 16; i++)
            eq[i] = (((q >> (2*i)) & 32'd3) == ((d >> (2*i)) & 32'd3));
        p = K;
        while (p <= 15 && exp_q.size() < mh) begin
            ok = 1'b1;
            for (int j = p - K; j < p; j++) ok = ok & eq[j];
            if (ok) begin
                exp_q.push_back(p);
                p = p + K;
            end else begin
                p = p + 1;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!irdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!irdy) check("idle_wait", 128'(irdy), 128'd1);
    endtask

    task automatic run_job(input logic [31:0] q, input logic [31:0] d,
                           input logic [15:0] qs, input logic [15:0] ds,
                           input int stall, input bit rnd);
        logic [127:0] base;
        logic [127:0] em;
        int  c0, n, stalled, nexp;
        bit  first, done;
        build_model(q, d, sel ? 2 : 16);
        nexp = exp_q.size();
        base = {16'd16, 16'd0, ds, qs, d, q};
        wait_idle();
        imsg = {ds, qs, d, q};
        val  = 1'b1;
        c0   = cyc;
        @(negedge clk);
        val  = 1'b0;
        imsg = {$urandom, $urandom, $urandom};
        first = 1'b1;
        done = 1'b0;
        stalled = 0;
        n = 0;
        while (!done && n < 400) begin
            if (oval) begin
                check("busy_rdy", 128'(irdy), 128'd0);
                if (exp_q.size() == 0) begin
                    check("extra_req", 128'(oval), 128'd0);
                end else begin
                    if (first)
                        check("first_lat", 128'(cyc),
                              128'(c0 + 2 + exp_q[0] - K));
                    em = base;
                    em[111:96] = 16'(exp_q[0]);
                    check("req_msg", omsg, em);
                end
                first = 1'b0;
                if (stalled < stall) begin
                    ordy = 1'b0;
                    stalled++;
                end else begin
                    ordy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
            end else begin
                check("msg_zero", omsg, 128'd0);
                ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (irdy) begin
                    done = 1'b1;
                    check("remaining", 128'(exp_q.size()), 128'd0);
                    if (nexp == 0)
                        check("done_lat", 128'(cyc), 128'(c0 + 16 - K + 1));
                end
            end
            if (!done) begin
                @(negedge clk);
                n++;
            end
        end
        if (!done) check("job_timeout", 128'(done), 128'd1);
    endtask

    initial begin
        logic [31:0] rq, rd;
        reset = 1'b1;
        val   = 1'b0;
        imsg  = '0;
        ordy  = 1'b0;
        sel   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_val", 128'(oval), 128'd0);
        check("rst_msg", omsg, 128'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rdy", 128'(irdy), 128'd1);

        run_job(32'h0, 32'h0, 16'h0010, 16'h0020, 0, 1'b0);
        run_job(32'h0, 32'hFFFFFFFF, 16'h1111, 16'h2222, 0, 1'b0);
        run_job(32'h0, 32'hFFFFFF00, 16'h0001, 16'h0002, 0, 1'b0);
        run_job(32'h0, 32'h0, 16'h0010, 16'h0020, 5, 1'b0);

        sel = 1'b1;
        run_job(32'h0, 32'h0, 16'h0030, 16'h0040, 0, 1'b0);
        wait_idle();
        sel = 1'b0;

        wait_idle();
        imsg = {16'h0020, 16'h0010, 32'h0, 32'h0};
        val  = 1'b1;
        @(negedge clk);
        val  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_val", 128'(oval), 128'd0);
        check("mid_rst_msg", omsg, 128'd0);
        check("mid_rst_rdy", 128'(irdy), 128'd1);
        run_job(32'h0, 32'h0, 16'h0010, 16'h0020, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            rq = $urandom;
            rd = rq;
            if ($urandom_range(0, 5) == 0) begin
                rd = $urandom;
            end else begin
                for (int i = 0; i < 16; i++)
                    if ($urandom_range(0, 4) == 0)
                        rd = rd ^ (32'($urandom_range(1, 3)) << (2*i));
            end
            run_job(rq, rd, 16'($urandom), 16'($urandom),
                    $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
